exe_mc: RTL

Parametrised multi-cycle MIPS-subset execute unit; successor to the fixed-width single-cycle `exe` block. Accepts 32-bit MIPS instruction words over a valid/ready stream and owns:
- a register file of `NREGS` × `XLEN`;
- a word-addressed data memory of `DMEM_DEPTH` words.

Executes one instruction at a time and reports each writeback or store on a one-cycle result strobe. Sits between the fetch stage and the debug/trace sink of the processor.

---
 rtl/exe_pkg.sv | 33 +++
 rtl/exe_alu.sv | 30 +++
 rtl/exe_mc.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the multi-cycle MIPS-subset execute unit.
// Holds the opcode/funct encodings, the FSM state enum and the ALU-op enum
// used by exe_mc and exe_alu.
package exe_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MEM
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

endpackage

// File: rtl/exe_alu.sv
// exe_alu: combinational ALU for the execute unit.
// Ports:
//   a, b : XLEN-bit operands
//   op   : operation select (alu_op_t)
//   y    : XLEN-bit result; add/sub wrap, slt yields 1/0 from a signed compare
module exe_alu
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] y
);

    // Pure combinational operation select; also used for address generation
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y[0] = ($signed(a) < $signed(b));
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/exe_mc.sv
// exe_mc: multi-cycle MIPS-subset execute unit (add/sub/and/or/slt, addi,
// lw, sw) with its own register file and word-addressed data memory.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   instr_valid/instr_ready  : instruction stream handshake
//   instr                    : 32-bit MIPS instruction word
//   res_valid                : one-cycle pulse per completed instruction
//   res_store                : 1 = store completed, 0 = register writeback
//   res_rd                   : destination register (0 for stores)
//   res_data                 : value written to register or memory
//   trap                     : one-cycle pulse for illegal/misaligned instructions
module exe_mc
    import exe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int DMEM_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            res_valid,
    output logic            res_store,
    output logic [4:0]      res_rd,
    output logic [XLEN-1:0] res_data,
    output logic            trap
);

    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int AW = $clog2(DMEM_DEPTH);
    localparam logic [5:0] NREGS_LIM = 6'(NREGS);

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] mem_rdata;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      dest;
    logic [15:0]     imm;
    logic            is_r;
    logic            is_addi;
    logic            is_lw;
    logic            is_sw;
    logic            funct_ok;
    logic            regs_ok;
    logic            misaligned;
    logic            illegal;
    alu_op_t         alu_op;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_y;
    logic [AW-1:0]   mem_idx;
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;
    logic            dm_we;
    logic            unused_shamt;

    assign opcode  = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign imm     = ir[15:0];
    assign funct   = ir[5:0];
    assign unused_shamt = ^ir[10:6];

    assign is_r    = (opcode == OP_RTYPE);
    assign is_addi = (opcode == OP_ADDI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign dest    = is_r ? rd : rt;
    assign imm_ext = XLEN'($signed(imm));

    // Map funct to an ALU op; non-R-type instructions always add (addi and
    // effective-address generation share the adder)
    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b0;
        case (funct)
            FN_ADD: begin alu_op = ALU_ADD; funct_ok = 1'b1; end
            FN_SUB: begin alu_op = ALU_SUB; funct_ok = 1'b1; end
            FN_AND: begin alu_op = ALU_AND; funct_ok = 1'b1; end
            FN_OR:  begin alu_op = ALU_OR;  funct_ok = 1'b1; end
            FN_SLT: begin alu_op = ALU_SLT; funct_ok = 1'b1; end
            default: ;
        endcase
        if (!is_r) begin
            alu_op = ALU_ADD;
        end
    end

    assign alu_b = is_r ? op_b : imm_ext;

    exe_alu #(.XLEN(XLEN)) u_alu (
        .a  (op_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    // rd only matters for R-type; I-type uses rs/rt
    assign regs_ok = ({1'b0, rs} < NREGS_LIM) && ({1'b0, rt} < NREGS_LIM)
                     && (!is_r || ({1'b0, rd} < NREGS_LIM));
    assign misaligned = (is_lw || is_sw) && (alu_y[1:0] != 2'b00);
    assign illegal = !((is_r && funct_ok) || is_addi || is_lw || is_sw)
                     || !regs_ok || misaligned;
    assign mem_idx = alu_y[AW+1:2];

    // Write ports: r0 writes are suppressed here, the result pulse still fires
    assign rf_we = !illegal && (dest != 5'd0)
                   && (((state == S_EXEC) && (is_r || is_addi)) || (state == S_MEM));
    assign rf_wdata = (state == S_MEM) ? mem_rdata : alu_y;
    assign dm_we = (state == S_EXEC) && is_sw && !illegal;

    // Flop-based register file, cleared by reset so every register reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we) begin
            regs[dest[RW-1:0]] <= rf_wdata;
        end
    end

    // Synchronous data RAM; the read is issued in S_EXEC and consumed in S_MEM
    always_ff @(posedge clk) begin
        if (dm_we) begin
            dmem[mem_idx] <= op_b;
        end
        mem_rdata <= dmem[mem_idx];
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            res_valid   <= 1'b0;
            res_store   <= 1'b0;
            res_rd      <= 5'd0;
            res_data    <= '0;
            trap        <= 1'b0;
            ir          <= '0;
            op_a        <= '0;
            op_b        <= '0;
        end else begin
            res_valid <= 1'b0;
            trap      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        ir          <= instr;
                        op_a        <= regs[instr[21 +: RW]];
                        op_b        <= regs[instr[16 +: RW]];
                        instr_ready <= 1'b0;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (illegal) begin
                        trap        <= 1'b1;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else if (is_lw) begin
                        state <= S_MEM;
                    end else begin
                        res_valid   <= 1'b1;
                        res_store   <= is_sw;
                        res_rd      <= is_sw ? 5'd0 : dest;
                        res_data    <= is_sw ? op_b : alu_y;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_MEM: begin
                    res_valid   <= 1'b1;
                    res_store   <= 1'b0;
                    res_rd      <= rt;
                    res_data    <= mem_rdata;
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
